// File: rtl/nes_pkg.sv
// Shared NES loader definitions: FSM states, rejection codes, image geometry
// and the iNES header rule table.
package nes_pkg;

  typedef enum logic [2:0] {IDLE, HDR, BODY, DONE, ERR} state_t;

  typedef enum logic [1:0] {
    EC_NONE   = 2'd0,
    EC_MAGIC  = 2'd1,
    EC_SIZE   = 2'd2,
    EC_MAPPER = 2'd3
  } err_code_t;

  localparam int unsigned IMAGE_BYTES_DEF = 'h6010;
  localparam int unsigned HDR_BYTES       = 16;
  localparam logic [31:0] INES_MAGIC      = 32'h4E45531A;

  // Rule for the header byte at position idx; positions 8 and up are unchecked.
  function automatic err_code_t hdr_check(input logic [14:0] idx, input logic [7:0] data);
    hdr_check = EC_NONE;
    case (idx)
      15'd0: if (data != INES_MAGIC[31:24]) hdr_check = EC_MAGIC;
      15'd1: if (data != INES_MAGIC[23:16]) hdr_check = EC_MAGIC;
      15'd2: if (data != INES_MAGIC[15:8])  hdr_check = EC_MAGIC;
      15'd3: if (data != INES_MAGIC[7:0])   hdr_check = EC_MAGIC;
      15'd4, 15'd5: if (data != 8'd1)       hdr_check = EC_SIZE;
      15'd6, 15'd7: if (data[7:4] != 4'd0)  hdr_check = EC_MAPPER;
      default: hdr_check = EC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Streams an iNES image into ROM, validating the 16-byte header on the fly.
module rom_loader
  import nes_pkg::*;
#(
  parameter int unsigned IMAGE_BYTES = IMAGE_BYTES_DEF
) (
  input  logic        ppu_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        prog,
  output logic [15:0] prog_ab,
  output logic [7:0]  prog_di,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [14:0] LAST_IDX = 15'(IMAGE_BYTES - 1);
  localparam logic [14:0] HDR_LAST = 15'(HDR_BYTES - 1);

  state_t      state;
  err_code_t   code_q;
  err_code_t   code_now;
  logic [14:0] idx;
  logic        accept;

  assign accept   = in_valid & in_ready;
  assign code_now = hdr_check(idx, in_data);
  assign err_code = code_q;

  always_ff @(posedge ppu_clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      prog     <= 1'b0;
      prog_ab  <= '0;
      prog_di  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      code_q   <= EC_NONE;
      in_ready <= 1'b0;
    end else begin
      prog <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            idx      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            code_q   <= EC_NONE;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= HDR;
          end
        end
        HDR, BODY: begin
          if (accept) begin
            // Every accepted byte is written, including a rejected header byte.
            idx     <= idx + 15'd1;
            prog    <= 1'b1;
            prog_ab <= {1'b0, idx};
            prog_di <= in_data;
            if (state == HDR && code_now != EC_NONE) begin
              state    <= ERR;
              err      <= 1'b1;
              code_q   <= code_now;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (idx == LAST_IDX) begin
              state    <= DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (state == HDR && idx == HDR_LAST) begin
              state <= BODY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
